// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM states, opcodes and every datapath mux/ALU encoding.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluctl_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // Immediate format depends only on the opcode, independent of FSM state.
  function automatic imm_src_e imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALUOp plus instruction funct fields to the
// 3-bit ALU operation code.
module aludec
  import mc_pkg::*;
(
  input  aluop_e      alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        op5_i,
  output aluctl_e     alu_control_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives the output and no latch is inferred.
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) with bit 30 set is a subtract; addi ignores bit 30.
          3'b000:  alu_control_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-FSM control unit for a multicycle RISC-V datapath.
// Define MCCTRL_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_retire,
  output logic       illegal_op
);

  state_e  state_q, state_d;
  aluop_e  alu_op;
  aluctl_e alu_ctl;
  logic    pc_update;
  logic    branch;
  logic    mem_ok;

`ifdef MCCTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // NOTE: synchronous reset, so reset appears only inside the clocked branch and
  // sequential state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update    = 1'b0;
    branch       = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RD2;
    alu_op       = ALUOP_ADD;
    instr_retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Instruction latch and PC+4 wait until the fetch read has completed.
        IRWrite   = mem_ok;
        pc_update = mem_ok;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_MEMWRITE: begin
        // Write strobe is held for the whole wait; retire only on the exit cycle.
        AdrSrc       = 1'b1;
        MemWrite     = 1'b1;
        instr_retire = mem_ok;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA      = SRCA_RD1;
        alu_op       = ALUOP_SUB;
        branch       = 1'b1;
        instr_retire = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite    = pc_update | (branch & Zero);
  assign ImmSrc     = imm_src_of(op);
  assign ALUControl = alu_ctl;

  aludec u_aludec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (alu_ctl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: each driven cycle queues its
// hand-computed output vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       instr_retire, illegal_op;

  typedef struct {
    logic [17:0] vec;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .instr_retire (instr_retire),
    .illegal_op   (illegal_op)
  );

  // Vector layout: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,
  //                 ALUSrcA,ALUSrcB,ImmSrc,ALUControl,instr_retire,illegal_op}
  function automatic logic [17:0] ev(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] res, a, b, imm,
                                     input logic [2:0] aluc,
                                     input logic ret, ill);
    return {pcw, adr, mw, irw, rw, res, a, b, imm, aluc, ret, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic [1:0] imm);
    return ev(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction

  function automatic logic [17:0] decode_v(input logic [1:0] imm);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                     ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_retire, illegal_op},
            e.vec);
    end
  end

  // Drive one clock cycle of inputs; when chk is set, queue the expected outputs.
  task automatic cyc(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic mr,
                     input logic chk, input logic [17:0] exp, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    op        = o;
    funct3    = f3;
    funct7b5  = f7;
    Zero      = z;
    mem_ready = mr;
    if (chk) begin
      e.vec  = exp;
      e.name = nm;
      sb_q.push_back(e);
    end
  endtask

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1111111;

  initial begin
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    cyc(1, LW, 3'b010, 0, 0, 1, 0, '0, "rst");
    cyc(1, LW, 3'b010, 0, 0, 1, 0, '0, "rst");

    // lw: 5 cycles, retire once in MEMWB
    cyc(0, LW, 3'b010, 0, 0, 1, 1, fetch_v(2'b00), "lw_fetch_after_reset");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, decode_v(2'b00), "lw_decode");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0), "lw_memadr");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, ev(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "lw_memread");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, ev(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,1,0), "lw_memwb");

    // beq taken (Zero=1) and not taken (Zero=0): 3 cycles each
    cyc(0, BEQ, 3'b000, 0, 1, 1, 1, fetch_v(2'b10), "beq_t_fetch");
    cyc(0, BEQ, 3'b000, 0, 1, 1, 1, decode_v(2'b10), "beq_t_decode");
    cyc(0, BEQ, 3'b000, 0, 1, 1, 1, ev(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0), "beq_taken");
    cyc(0, BEQ, 3'b000, 0, 0, 1, 1, fetch_v(2'b10), "beq_n_fetch");
    cyc(0, BEQ, 3'b000, 0, 0, 1, 1, decode_v(2'b10), "beq_n_decode");
    cyc(0, BEQ, 3'b000, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0), "beq_not_taken");

    // R-type sub / or / slt: EXECUTER then ALUWB
    cyc(0, RT, 3'b000, 1, 0, 1, 1, fetch_v(2'b00), "sub_fetch");
    cyc(0, RT, 3'b000, 1, 0, 1, 1, decode_v(2'b00), "sub_decode");
    cyc(0, RT, 3'b000, 1, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0), "sub_execr");
    cyc(0, RT, 3'b000, 1, 0, 1, 1, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0), "sub_aluwb");
    cyc(0, RT, 3'b110, 0, 0, 1, 1, fetch_v(2'b00), "or_fetch");
    cyc(0, RT, 3'b110, 0, 0, 1, 1, decode_v(2'b00), "or_decode");
    cyc(0, RT, 3'b110, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0,0), "or_execr");
    cyc(0, RT, 3'b110, 0, 0, 1, 1, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0), "or_aluwb");
    cyc(0, RT, 3'b010, 0, 0, 1, 1, fetch_v(2'b00), "slt_fetch");
    cyc(0, RT, 3'b010, 0, 0, 1, 1, decode_v(2'b00), "slt_decode");
    cyc(0, RT, 3'b010, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0), "slt_execr");
    cyc(0, RT, 3'b010, 0, 0, 1, 1, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0), "slt_aluwb");

    // addi with bit30 set stays add (op[5]=0); andi -> and
    cyc(0, IT, 3'b000, 1, 0, 1, 1, fetch_v(2'b00), "addi_fetch");
    cyc(0, IT, 3'b000, 1, 0, 1, 1, decode_v(2'b00), "addi_decode");
    cyc(0, IT, 3'b000, 1, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0), "addi_execi");
    cyc(0, IT, 3'b000, 1, 0, 1, 1, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0), "addi_aluwb");
    cyc(0, IT, 3'b111, 0, 0, 1, 1, fetch_v(2'b00), "andi_fetch");
    cyc(0, IT, 3'b111, 0, 0, 1, 1, decode_v(2'b00), "andi_decode");
    cyc(0, IT, 3'b111, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010,0,0), "andi_execi");
    cyc(0, IT, 3'b111, 0, 0, 1, 1, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0), "andi_aluwb");

    // jal: 4 cycles, PCWrite in JAL
    cyc(0, JAL, 3'b000, 0, 0, 1, 1, fetch_v(2'b11), "jal_fetch");
    cyc(0, JAL, 3'b000, 0, 0, 1, 1, decode_v(2'b11), "jal_decode");
    cyc(0, JAL, 3'b000, 0, 0, 1, 1, ev(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0), "jal_jal");
    cyc(0, JAL, 3'b000, 0, 0, 1, 1, ev(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000,1,0), "jal_aluwb");

    // illegal opcode: pulse in DECODE, straight back to FETCH
    cyc(0, ILL, 3'b000, 0, 0, 1, 1, fetch_v(2'b00), "ill_fetch");
    cyc(0, ILL, 3'b000, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1), "ill_decode");

`ifdef MCCTRL_MEM_WAIT_EN
    // fetch stall gates IRWrite/PCWrite; sw waits 3 cycles in MEMWRITE
    cyc(0, SW, 3'b010, 0, 0, 0, 1, ev(0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0), "sw_fetch_wait");
    cyc(0, SW, 3'b010, 0, 0, 1, 1, fetch_v(2'b01), "sw_fetch");
    cyc(0, SW, 3'b010, 0, 0, 1, 1, decode_v(2'b01), "sw_decode");
    cyc(0, SW, 3'b010, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0), "sw_memadr");
    for (int i = 0; i < 3; i++)
      cyc(0, SW, 3'b010, 0, 0, 0, 1, ev(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0), "sw_memwrite_wait");
    cyc(0, SW, 3'b010, 0, 0, 1, 1, ev(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1,0), "sw_memwrite_exit");
`else
    // mem_ready is ignored: sw still takes 4 cycles with mem_ready low
    cyc(0, SW, 3'b010, 0, 0, 0, 1, fetch_v(2'b01), "sw_fetch");
    cyc(0, SW, 3'b010, 0, 0, 0, 1, decode_v(2'b01), "sw_decode");
    cyc(0, SW, 3'b010, 0, 0, 0, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0), "sw_memadr");
    cyc(0, SW, 3'b010, 0, 0, 0, 1, ev(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1,0), "sw_memwrite");
`endif

    // reset during MEMREAD (mem_ready low): back to FETCH, no RegWrite
    cyc(0, LW, 3'b010, 0, 0, 1, 1, fetch_v(2'b00), "rstmr_fetch");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, decode_v(2'b00), "rstmr_decode");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, ev(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0), "rstmr_memadr");
    cyc(1, LW, 3'b010, 0, 0, 0, 1, ev(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0), "rstmr_memread");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, fetch_v(2'b00), "rstmr_fetch_after");
    cyc(0, LW, 3'b010, 0, 0, 1, 1, decode_v(2'b00), "rstmr_decode_after");

    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
